// File: rtl/hwag_angle_channel_if.sv
// Configuration bus of one angle channel: shadow write strobe and data in,
// pending and rejection status out.
interface hwag_angle_channel_if #(
    parameter int WIDTH = 24
);
    logic             cfg_wr;
    logic [WIDTH-1:0] cfg_set;
    logic [WIDTH-1:0] cfg_clr;
    logic             cfg_en;
    logic             pending;
    logic             cfg_err;

    modport master (
        output cfg_wr, cfg_set, cfg_clr, cfg_en,
        input  pending, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_set, cfg_clr, cfg_en,
        output pending, cfg_err
    );
endinterface

// File: rtl/hwag_angle_channel.sv
// Angle-triggered output channel: asserts ch_out between two programmable
// angle counts, with double-buffered configuration applied between pulses.
module hwag_angle_channel #(
    parameter int WIDTH    = 24,
    parameter int ACNT_TOP = 3839
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  hwag_start,
    input  logic [WIDTH-1:0]      acnt,
    hwag_angle_channel_if.slave   cfg,
    output logic                  ch_out,
    output logic                  done
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(ACNT_TOP);

    typedef enum logic [1:0] {IDLE, WAIT_SET, ACTIVE} state_t;

    state_t           state;
    state_t           state_next;
    logic             done_next;
    logic [WIDTH-1:0] acnt_d;
    logic [WIDTH-1:0] shd_set;
    logic [WIDTH-1:0] shd_clr;
    logic             shd_en;
    logic [WIDTH-1:0] act_set;
    logic [WIDTH-1:0] act_clr;
    logic             act_en;
    logic             pending_q;
    logic             cfg_err_q;
    logic             set_hit;
    logic             clr_hit;
    logic             cfg_bad;

    // A hit fires only on the first cycle acnt reaches the angle, since acnt dwells.
    assign set_hit = (acnt == act_set) && (acnt_d != act_set);
    assign clr_hit = (acnt == act_clr) && (acnt_d != act_clr);
    assign cfg_bad = (cfg.cfg_set > TOP) || (cfg.cfg_clr > TOP);

    assign ch_out      = (state == ACTIVE);
    assign cfg.pending = pending_q;
    assign cfg.cfg_err = cfg_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else if (ena) begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (hwag_start && act_en)
                    state_next = WAIT_SET;
            end
            WAIT_SET: begin
                if (!hwag_start || !act_en)
                    state_next = IDLE;
                else if (set_hit && !clr_hit)
                    state_next = ACTIVE;
            end
            ACTIVE: begin
                // Losing sync aborts the pulse silently; only a clear angle reports done.
                if (!hwag_start) begin
                    state_next = IDLE;
                end else if (clr_hit) begin
                    state_next = WAIT_SET;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shadow is copied to the active set only outside a pulse; a write in the
    // same cycle re-arms pending so the newest data is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acnt_d    <= '0;
            shd_set   <= '0;
            shd_clr   <= '0;
            shd_en    <= 1'b0;
            act_set   <= '0;
            act_clr   <= '0;
            act_en    <= 1'b0;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else if (ena) begin
            acnt_d    <= acnt;
            cfg_err_q <= 1'b0;
            if (pending_q && (state != ACTIVE)) begin
                act_set   <= shd_set;
                act_clr   <= shd_clr;
                act_en    <= shd_en;
                pending_q <= 1'b0;
            end
            if (cfg.cfg_wr) begin
                if (cfg_bad) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    shd_set   <= cfg.cfg_set;
                    shd_clr   <= cfg.cfg_clr;
                    shd_en    <= cfg.cfg_en;
                    pending_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_hwag_angle_channel.sv
// Directed bench for hwag_angle_channel: table of angle windows swept over a
// revolution, plus hand sequences for rejection, deferral, sync loss and reset.
module tb_hwag_angle_channel;
    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        hwag_start;
    logic [23:0] acnt;
    logic        ch_out;
    logic        done;

    hwag_angle_channel_if #(.WIDTH(24)) cfg_bus ();

    hwag_angle_channel #(.WIDTH(24), .ACNT_TOP(3839)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .hwag_start (hwag_start),
        .acnt       (acnt),
        .cfg        (cfg_bus.slave),
        .ch_out     (ch_out),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int set_v;
        int clr_v;
        int start;
        int n;
        int exp_rise;
        int exp_fall;
        int exp_done_at;
        int exp_done_cnt;
        int exp_zero;
    } vec_t;

    vec_t vecs[4];
    int   errors = 0;
    int   checks = 0;
    int   rise_code;
    int   fall_code;
    int   done_at;
    int   done_cnt;
    int   at_zero;
    int   last_ch;

    // Observed events are coded as acnt*2 + dwell cycle index.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic writeCfg(input int s, input int c, input logic en);
        cfg_bus.cfg_set = 24'(s);
        cfg_bus.cfg_clr = 24'(c);
        cfg_bus.cfg_en  = en;
        cfg_bus.cfg_wr  = 1'b1;
        tick();
        cfg_bus.cfg_wr  = 1'b0;
    endtask

    task automatic clearObs();
        rise_code = -1;
        fall_code = -1;
        done_at   = -1;
        done_cnt  = 0;
        at_zero   = -1;
        last_ch   = int'(ch_out);
    endtask

    task automatic applyStimulus(input int start, input int n);
        int v;
        int code;
        for (int i = 0; i < n; i++) begin
            v    = (start + i) % 3840;
            acnt = 24'(v);
            for (int rep = 0; rep < 2; rep++) begin
                tick();
                code = v * 2 + rep;
                if (ch_out && last_ch == 0 && rise_code < 0) rise_code = code;
                if (!ch_out && last_ch == 1 && fall_code < 0) fall_code = code;
                if (done) begin
                    done_cnt++;
                    if (done_at < 0) done_at = code;
                end
                if (v == 0 && rep == 1) at_zero = int'(ch_out);
                last_ch = int'(ch_out);
            end
        end
    endtask

    initial begin
        vecs[0] = '{100,  200,  0,    3840, 200,  400, 400, 1, 0};
        vecs[1] = '{3800, 40,   3700, 300,  7600, 80,  80,  1, 1};
        vecs[2] = '{500,  500,  0,    3840, -1,   -1,  -1,  0, 0};
        vecs[3] = '{3839, 0,    3800, 100,  7678, 0,   0,   1, 0};

        rst = 1'b0;
        ena = 1'b1;
        hwag_start = 1'b1;
        acnt = '0;
        cfg_bus.cfg_wr = 1'b0;
        cfg_bus.cfg_set = '0;
        cfg_bus.cfg_clr = '0;
        cfg_bus.cfg_en = 1'b0;
        #12;
        checkOutput("reset_ch_out", int'(ch_out), 0);
        checkOutput("reset_pending", int'(cfg_bus.pending), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_cfg_err", int'(cfg_bus.cfg_err), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            acnt = 24'(vecs[i].start);
            writeCfg(vecs[i].set_v, vecs[i].clr_v, 1'b1);
            checkOutput($sformatf("v%0d_pending_set", i), int'(cfg_bus.pending), 1);
            tick();
            checkOutput($sformatf("v%0d_pending_clr", i), int'(cfg_bus.pending), 0);
            tick();
            clearObs();
            applyStimulus(vecs[i].start, vecs[i].n);
            checkOutput($sformatf("v%0d_rise", i), rise_code, vecs[i].exp_rise);
            checkOutput($sformatf("v%0d_fall", i), fall_code, vecs[i].exp_fall);
            checkOutput($sformatf("v%0d_done_at", i), done_at, vecs[i].exp_done_at);
            checkOutput($sformatf("v%0d_done_cnt", i), done_cnt, vecs[i].exp_done_cnt);
            checkOutput($sformatf("v%0d_at_zero", i), at_zero, vecs[i].exp_zero);
        end

        // Out-of-range writes are rejected and leave the 3839/0 window intact.
        writeCfg(10, 3840, 1'b1);
        checkOutput("bad_clr_err", int'(cfg_bus.cfg_err), 1);
        checkOutput("bad_clr_pending", int'(cfg_bus.pending), 0);
        tick();
        checkOutput("bad_err_strobe", int'(cfg_bus.cfg_err), 0);
        writeCfg(3840, 5, 1'b1);
        checkOutput("bad_set_err", int'(cfg_bus.cfg_err), 1);
        tick();
        clearObs();
        applyStimulus(3800, 100);
        checkOutput("bad_keep_rise", rise_code, 7678);
        checkOutput("bad_keep_fall", fall_code, 0);

        // Reconfiguration during a pulse is deferred until the pulse ends.
        acnt = '0;
        writeCfg(100, 200, 1'b1);
        tick();
        clearObs();
        applyStimulus(0, 151);
        checkOutput("defer_rise", rise_code, 200);
        writeCfg(150, 300, 1'b1);
        applyStimulus(151, 49);
        checkOutput("defer_pending_hi", int'(cfg_bus.pending), 1);
        checkOutput("defer_still_on", int'(ch_out), 1);
        clearObs();
        applyStimulus(200, 3640);
        checkOutput("defer_old_fall", fall_code, 400);
        checkOutput("defer_done_cnt", done_cnt, 1);
        checkOutput("defer_pending_lo", int'(cfg_bus.pending), 0);
        clearObs();
        applyStimulus(0, 3840);
        checkOutput("defer_new_rise", rise_code, 300);
        checkOutput("defer_new_fall", fall_code, 600);

        // Sync loss mid-pulse, then reset mid-pulse with a write pending.
        writeCfg(100, 200, 1'b1);
        tick();
        clearObs();
        applyStimulus(0, 151);
        checkOutput("sync_pulse_on", int'(ch_out), 1);
        hwag_start = 1'b0;
        tick();
        checkOutput("sync_drop_ch_out", int'(ch_out), 0);
        checkOutput("sync_drop_done", int'(done), 0);
        hwag_start = 1'b1;
        tick();
        clearObs();
        applyStimulus(90, 30);
        checkOutput("resync_rise", rise_code, 200);
        writeCfg(700, 800, 1'b1);
        checkOutput("pre_reset_pending", int'(cfg_bus.pending), 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_ch_out", int'(ch_out), 0);
        checkOutput("async_rst_pending", int'(cfg_bus.pending), 0);
        checkOutput("async_rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // With ena low a write strobe is ignored.
        ena = 1'b0;
        writeCfg(10, 20, 1'b1);
        checkOutput("ena_low_ignore", int'(cfg_bus.pending), 0);
        ena = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
